// File: rtl/cordic2_pkg.sv
// cordic2 shared types and elaboration-time constants:
// FSM encoding, CORDIC gain compensation and atan table.
package cordic2_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREROT,
    S_ITERATE,
    S_DONE
  } state_t;

  localparam int MAX_ITER = 24;
  localparam int TAB_W = 32;
  localparam real PI = 3.14159265358979323846;

  typedef logic [MAX_ITER-1:0][TAB_W-1:0] atan_tab_t;

  // 1.0 scaled down by the CORDIC gain so |result| lands on 1.0
  function automatic int k0_val(input int data_w);
    real k;
    k = (2.0 ** (data_w - 2)) / 1.646760;
    return $rtoi(k + 0.5);
  endfunction

  // atan(2^-i) in phase units where 2^(data_w+2) is a full turn
  function automatic atan_tab_t atan_table(
    input int data_w,
    input int iter
  );
    atan_tab_t t;
    real a;
    t = '0;
    for (int i = 0; i < MAX_ITER; i++) begin
      if (i < iter) begin
        a = $atan(2.0 ** (-i));
        a = a * (2.0 ** (data_w + 2)) / (2.0 * PI);
        t[i] = TAB_W'($rtoi(a + 0.5));
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/cordic2_atan_lut.sv
// cordic2 arctangent lookup, iteration index to
// micro-rotation angle.
module cordic2_atan_lut
  import cordic2_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ITER = 16,
  parameter int CNT_W = 4
) (
  input  logic [CNT_W-1:0]         idx,
  output logic signed [DATA_W+1:0] atan
);

  localparam atan_tab_t TAB = atan_table(DATA_W, ITER);

  always_comb begin
    atan = '0;
    for (int i = 0; i < ITER; i++) begin
      if (idx == CNT_W'(i)) begin
        atan = TAB[i][DATA_W+1:0];
      end
    end
  end

endmodule

// File: rtl/cordic2_rotator.sv
// cordic2 iterative CORDIC rotator: phase word in,
// cos/sin out after ITER+2 cycles.
module cordic2_rotator
  import cordic2_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ITER = 16
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     start,
  input  logic [DATA_W-1:0]        phase_in,
  output logic signed [DATA_W-1:0] cos_out,
  output logic signed [DATA_W-1:0] sin_out,
  output logic                     valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int IW = DATA_W + 2;
  localparam int CNT_W = $clog2(ITER);
  localparam logic signed [IW-1:0] K0S =
    IW'(k0_val(DATA_W) * 4);
  localparam logic signed [IW:0] MAXP =
    (IW+1)'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [IW:0] MINP = -MAXP;

  state_t state, state_nxt;

  logic [DATA_W-1:0]   phase_q;
  logic signed [IW-1:0] x, y, z;
  logic signed [IW-1:0] x_nxt, y_nxt, z_nxt;
  logic signed [IW-1:0] x_sh, y_sh, atan_i;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                accept, last, flip, load_out;

  cordic2_atan_lut #(
    .DATA_W (DATA_W),
    .ITER   (ITER),
    .CNT_W  (CNT_W)
  ) u_lut (
    .idx  (cnt),
    .atan (atan_i)
  );

  // round-half-up on the guard bits, then clamp
  function automatic logic signed [DATA_W-1:0] to_out(
    input logic signed [IW-1:0] v
  );
    logic signed [IW:0] r;
    r = {v[IW-1], v} + (IW+1)'(2);
    r = r >>> 2;
    if (r > MAXP) r = MAXP;
    else if (r < MINP) r = MINP;
    return r[DATA_W-1:0];
  endfunction

  assign busy = (state == S_PREROT) ||
                (state == S_ITERATE);
  assign valid = (state == S_DONE);
  assign accept = start &&
    ((state == S_IDLE) || (state == S_DONE));
  assign last = (cnt == CNT_W'(ITER - 1));
  assign flip = phase_q[DATA_W-1] ^ phase_q[DATA_W-2];
  assign load_out = (state == S_ITERATE) && last;
  assign x_sh = x >>> cnt;
  assign y_sh = y >>> cnt;

  always_comb begin
    state_nxt = state;
    x_nxt = x;
    y_nxt = y;
    z_nxt = z;
    cnt_nxt = cnt;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_PREROT;
      end
      S_PREROT: begin
        // fold left half-plane onto the right by a pi turn
        x_nxt = flip ? -K0S : K0S;
        y_nxt = '0;
        z_nxt = {phase_q[DATA_W-1] ^ flip,
                 phase_q[DATA_W-2:0], 2'b00};
        cnt_nxt = '0;
        state_nxt = S_ITERATE;
      end
      S_ITERATE: begin
        if (z[IW-1]) begin
          x_nxt = x + y_sh;
          y_nxt = y - x_sh;
          z_nxt = z + atan_i;
        end else begin
          x_nxt = x - y_sh;
          y_nxt = y + x_sh;
          z_nxt = z - atan_i;
        end
        cnt_nxt = cnt + 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = start ? S_PREROT : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state   <= S_IDLE;
      phase_q <= '0;
      x       <= '0;
      y       <= '0;
      z       <= '0;
      cnt     <= '0;
      cos_out <= '0;
      sin_out <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      x     <= x_nxt;
      y     <= y_nxt;
      z     <= z_nxt;
      cnt   <= cnt_nxt;
      if (accept) phase_q <= phase_in;
      if (accept) overrun <= 1'b0;
      else if (start && busy) overrun <= 1'b1;
      // results appear in the DONE cycle itself
      if (load_out) begin
        cos_out <= to_out(x_nxt);
        sin_out <= to_out(y_nxt);
      end
    end
  end

endmodule

// File: tb/tb_cordic2_rotator.sv
// Directed bench for cordic2_rotator at DATA_W=16, ITER=16:
// quadrants, latency, overrun, back-to-back, mid-run reset.
module tb_cordic2_rotator;

  localparam int LAT = 18;
  localparam int TOL = 3;

  logic               ACLK = 1'b0;
  logic               ARESETN = 1'b1;
  logic               start = 1'b0;
  logic [15:0]        phase_in = '0;
  logic signed [15:0] cos_out, sin_out;
  logic               valid, busy, overrun;

  int checks = 0;
  int errors = 0;

  cordic2_rotator #(
    .DATA_W (16),
    .ITER   (16)
  ) dut (
    .ACLK     (ACLK),
    .ARESETN  (ARESETN),
    .start    (start),
    .phase_in (phase_in),
    .cos_out  (cos_out),
    .sin_out  (sin_out),
    .valid    (valid),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 ACLK = ~ACLK;

  // leaves the bench at mid-cycle 1 after start
  task automatic do_start(input logic [15:0] ph);
    @(negedge ACLK);
    start = 1'b1;
    phase_in = ph;
    @(negedge ACLK);
    start = 1'b0;
    phase_in = 16'hDEAD;
  endtask

  task automatic run_calc(
    input  logic [15:0] ph,
    output int lat,
    output int nval,
    output int bbad
  );
    lat = -1;
    nval = 0;
    bbad = 0;
    do_start(ph);
    for (int k = 1; k <= 30; k++) begin
      if (valid === 1'b1) begin
        nval++;
        if (lat < 0) lat = k;
      end
      if (k <= LAT - 1 && busy !== 1'b1) bbad++;
      if (k >= LAT && busy !== 1'b0) bbad++;
      @(negedge ACLK);
    end
  endtask

  task automatic test_reset;
    #3 ARESETN = 1'b0;
    #1;
    checks++;
    if ({cos_out, sin_out, valid, busy, overrun}
        !== 35'd0) begin
      errors++;
      $display("FAIL reset: cos=%0d sin=%0d v=%b b=%b o=%b",
               cos_out, sin_out, valid, busy, overrun);
    end
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: v=%b b=%b want 0 0",
               valid, busy);
    end
  endtask

  task automatic test_quadrants;
    logic [15:0] ph [6];
    int ec [6];
    int es [6];
    int lat, nval, bbad, dc, ds;
    ph = '{16'h0000, 16'h4000, 16'h8000,
           16'hC000, 16'h2000, 16'h6000};
    ec = '{16384, 0, -16384, 0, 11585, -11585};
    es = '{0, 16384, 0, -16384, 11585, 11585};
    for (int t = 0; t < 6; t++) begin
      run_calc(ph[t], lat, nval, bbad);
      checks++;
      if (lat !== LAT || nval !== 1) begin
        errors++;
        $display("FAIL latency ph=%h: lat=%0d n=%0d want %0d 1",
                 ph[t], lat, nval, LAT);
      end
      checks++;
      if (bbad !== 0) begin
        errors++;
        $display("FAIL busy ph=%h: %0d bad cycles want 0",
                 ph[t], bbad);
      end
      dc = int'(cos_out) - ec[t];
      ds = int'(sin_out) - es[t];
      checks++;
      if (dc > TOL || dc < -TOL || ds > TOL || ds < -TOL) begin
        errors++;
        $display("FAIL result ph=%h: got (%0d,%0d) want (%0d,%0d)",
                 ph[t], cos_out, sin_out, ec[t], es[t]);
      end
    end
  endtask

  task automatic test_overrun;
    int lat, nval, ov_early, ov_late;
    lat = -1;
    nval = 0;
    ov_early = -1;
    ov_late = -1;
    do_start(16'h0000);
    for (int k = 1; k <= 30; k++) begin
      if (valid === 1'b1) begin
        nval++;
        if (lat < 0) lat = k;
      end
      if (k == 5) ov_early = int'(overrun);
      if (k == 30) ov_late = int'(overrun);
      start = (k == 5) || (k == 10);
      phase_in = (k == 5) ? 16'h4000 : 16'h8000;
      @(negedge ACLK);
      start = 1'b0;
    end
    checks++;
    if (lat !== LAT || nval !== 1) begin
      errors++;
      $display("FAIL ovr_valid: lat=%0d n=%0d want %0d 1",
               lat, nval, LAT);
    end
    checks++;
    if (ov_early !== 0 || ov_late !== 1) begin
      errors++;
      $display("FAIL ovr_flag: c5=%0d c30=%0d want 0 1",
               ov_early, ov_late);
    end
    checks++;
    if (cos_out < 16381 || sin_out > 3 || sin_out < -3) begin
      errors++;
      $display("FAIL ovr_result: got (%0d,%0d) want (16384,0)",
               cos_out, sin_out);
    end
    do_start(16'h4000);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear: got %b want 0", overrun);
    end
    repeat (20) @(negedge ACLK);
  endtask

  task automatic test_back_to_back;
    int v1, v2, nval, held_bad;
    logic signed [15:0] c1, s1;
    v1 = -1;
    v2 = -1;
    nval = 0;
    held_bad = 0;
    c1 = '0;
    s1 = '0;
    do_start(16'h0000);
    for (int k = 1; k <= 45; k++) begin
      if (valid === 1'b1) begin
        nval++;
        if (v1 < 0) v1 = k;
        else if (v2 < 0) v2 = k;
      end
      if (k == LAT) begin
        c1 = cos_out;
        s1 = sin_out;
      end
      if (k > LAT && k < 2 * LAT &&
          (cos_out !== c1 || sin_out !== s1)) held_bad++;
      start = (k == LAT);
      phase_in = 16'h4000;
      @(negedge ACLK);
      start = 1'b0;
    end
    checks++;
    if (v1 !== LAT || v2 !== 2 * LAT || nval !== 2) begin
      errors++;
      $display("FAIL b2b_timing: v1=%0d v2=%0d n=%0d want %0d %0d 2",
               v1, v2, nval, LAT, 2 * LAT);
    end
    checks++;
    if (held_bad !== 0 || c1 < 16381) begin
      errors++;
      $display("FAIL b2b_hold: bad=%0d c1=%0d want 0 16384",
               held_bad, c1);
    end
    checks++;
    if (sin_out < 16381 || cos_out > 3 || cos_out < -3) begin
      errors++;
      $display("FAIL b2b_result: got (%0d,%0d) want (0,16384)",
               cos_out, sin_out);
    end
  endtask

  task automatic test_reset_mid;
    int nval, lat, bbad;
    nval = 0;
    do_start(16'h4000);
    repeat (7) @(negedge ACLK);
    ARESETN = 1'b0;
    #1;
    checks++;
    if ({cos_out, sin_out, valid, busy, overrun}
        !== 35'd0) begin
      errors++;
      $display("FAIL rst_mid: cos=%0d sin=%0d v=%b b=%b o=%b",
               cos_out, sin_out, valid, busy, overrun);
    end
    @(negedge ACLK);
    ARESETN = 1'b1;
    for (int k = 0; k < 25; k++) begin
      if (valid === 1'b1) nval++;
      @(negedge ACLK);
    end
    checks++;
    if (nval !== 0) begin
      errors++;
      $display("FAIL rst_novalid: got %0d pulses want 0", nval);
    end
    run_calc(16'h0000, lat, nval, bbad);
    checks++;
    if (lat !== LAT || nval !== 1 || bbad !== 0) begin
      errors++;
      $display("FAIL rst_restart: lat=%0d n=%0d bb=%0d want %0d 1 0",
               lat, nval, bbad, LAT);
    end
    checks++;
    if (cos_out < 16381 || sin_out > 3 || sin_out < -3) begin
      errors++;
      $display("FAIL rst_result: got (%0d,%0d) want (16384,0)",
               cos_out, sin_out);
    end
  endtask

  initial begin
    test_reset();
    test_quadrants();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
